// File: rtl/rv_memory.sv
// Byte-addressable memory with a valid/ready request port, programmable wait
// states and a one-cycle registered response pulse; sub-word loads extend.
module rv_memory #(
   parameter int MEM_SIZE    = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [3:0]  req_width,
   input  logic        req_signed,
   input  logic [31:0] req_address,
   input  logic [31:0] req_data,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_error
);

   localparam int AW    = $clog2(MEM_SIZE);
   localparam int DEPTH = MEM_SIZE / 4;
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t          state_reg, state_next;
   logic [3:0]      count_reg;
   logic            write_reg, signed_reg;
   logic [3:0]      width_reg;
   logic [AW-1:0]   address_reg;
   logic [31:0]     data_reg;
   logic            accept, access;

   logic [7:0]      cells0 [DEPTH];
   logic [7:0]      cells1 [DEPTH];
   logic [7:0]      cells2 [DEPTH];
   logic [7:0]      cells3 [DEPTH];

   logic [IW-1:0]   index;
   logic [1:0]      offset;
   logic            width_ok;
   logic            store_en;
   logic [3:0]      lane_we;
   logic [31:0]     lane_wd;
   logic [31:0]     rd_word;
   logic [31:0]     load_value;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;
   logic            unused_addr_bits;

   // Address bits above the memory size wrap and are never looked at.
   assign unused_addr_bits = ^req_address[31:AW];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (req_valid) state_next = ST_WAIT;
         ST_WAIT: if (count_reg == 4'd0) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_reg == ST_IDLE);
      accept    = req_ready && req_valid;
      access    = (state_reg == ST_WAIT) && (count_reg == 4'd0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg   <= 4'd0;
         write_reg   <= 1'b0;
         signed_reg  <= 1'b0;
         width_reg   <= 4'd0;
         address_reg <= '0;
         data_reg    <= 32'd0;
      end else if (accept) begin
         count_reg   <= 4'(WAIT_STATES);
         write_reg   <= req_write;
         signed_reg  <= req_signed;
         width_reg   <= req_width;
         address_reg <= req_address[AW-1:0];
         data_reg    <= req_data;
      end else if (state_reg == ST_WAIT && count_reg != 4'd0) begin
         count_reg   <= count_reg - 4'd1;
      end
   end

   generate
      if (DEPTH > 1) begin : g_index
         assign index = address_reg[AW-1:2];
      end else begin : g_index_single
         assign index = '0;
      end
   endgenerate

   assign offset = address_reg[1:0];

   always_comb begin
      case (width_reg)
         4'd1:    width_ok = 1'b1;
         4'd2:    width_ok = (offset[0] == 1'b0);
         4'd4:    width_ok = (offset == 2'd0);
         default: width_ok = 1'b0;
      endcase
   end

   // Reset is folded in so that an access edge coinciding with reset never writes.
   assign store_en = access && write_reg && width_ok && reset;

   always_comb begin
      case (width_reg)
         4'd1:    lane_wd = {4{data_reg[7:0]}};
         4'd2:    lane_wd = {2{data_reg[15:0]}};
         default: lane_wd = data_reg;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
         assign lane_we[gi] = store_en &&
            ((width_reg == 4'd4) ||
             (width_reg == 4'd2 && offset[1] == gi[1]) ||
             (width_reg == 4'd1 && offset == gi[1:0]));
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (lane_we[0]) cells0[index] <= lane_wd[7:0];
      if (lane_we[1]) cells1[index] <= lane_wd[15:8];
      if (lane_we[2]) cells2[index] <= lane_wd[23:16];
      if (lane_we[3]) cells3[index] <= lane_wd[31:24];
   end

   assign rd_word = {cells3[index], cells2[index], cells1[index], cells0[index]};

   always_comb begin
      rd_byte = rd_word[8*offset +: 8];
      rd_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
      case (width_reg)
         4'd1:    load_value = {{24{signed_reg & rd_byte[7]}}, rd_byte};
         4'd2:    load_value = {{16{signed_reg & rd_half[15]}}, rd_half};
         default: load_value = rd_word;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_data  <= 32'd0;
         rsp_error <= 1'b0;
      end else begin
         rsp_valid <= access;
         if (access) begin
            rsp_error <= !width_ok;
            rsp_data  <= (width_ok && !write_reg) ? load_value : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_rv_memory.sv
// Drives two memories (0 and 3 wait states) with the same requests and checks
// both against a byte-array reference model through per-instance scoreboards.
module tb_rv_memory;

   localparam int MEM  = 1024;
   localparam int WS_B = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [3:0]  req_width = 4'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_address = 32'd0;
   logic [31:0] req_data = 32'd0;
   logic [1:0]  rdy, vld, er;
   logic [31:0] rd0, rd1;

   always #5 clock = ~clock;

   rv_memory #(.MEM_SIZE(MEM), .WAIT_STATES(0)) dut0 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_write(req_write), .req_width(req_width), .req_signed(req_signed),
      .req_address(req_address), .req_data(req_data),
      .rsp_valid(vld[0]), .rsp_data(rd0), .rsp_error(er[0]));

   rv_memory #(.MEM_SIZE(MEM), .WAIT_STATES(WS_B)) dut1 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_write(req_write), .req_width(req_width), .req_signed(req_signed),
      .req_address(req_address), .req_data(req_data),
      .rsp_valid(vld[1]), .rsp_data(rd1), .rsp_error(er[1]));

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          due;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] last_data [2];
   logic        last_err  [2];
   logic [7:0]  model [MEM];
   int          errors = 0;
   int          checks = 0;
   int          cycle  = 0;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
      end
   endtask

   task automatic monitor_one(input int id);
      exp_t        e;
      logic [31:0] data;
      logic        busy;
      int          qsize;
      data  = (id == 0) ? rd0 : rd1;
      qsize = (id == 0) ? q0.size() : q1.size();
      if (qsize > 0) e = (id == 0) ? q0[0] : q1[0];
      if (!reset) begin
         chk($sformatf("d%0d_reset_valid", id), {31'd0, vld[id]}, 32'd0);
         chk($sformatf("d%0d_reset_data", id), data, 32'd0);
         return;
      end
      busy = (qsize > 0) && (cycle < e.due);
      chk($sformatf("d%0d_ready", id), {31'd0, rdy[id]}, {31'd0, !busy});
      if (vld[id]) begin
         if (qsize == 0) begin
            checks++;
            errors++;
            $display("FAIL d%0d_unexpected_rsp: got rsp_valid=1 expected no response", id);
         end else begin
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk($sformatf("d%0d_latency", id), cycle, e.due);
            chk($sformatf("d%0d_rsp_data", id), data, e.data);
            chk($sformatf("d%0d_rsp_error", id), {31'd0, er[id]}, {31'd0, e.err});
            last_data[id] = e.data;
            last_err[id]  = e.err;
         end
      end else begin
         if (qsize > 0 && cycle >= e.due) begin
            checks++;
            errors++;
            $display("FAIL d%0d_timeout: got no response expected one at cycle %0d", id, e.due);
            if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
         chk($sformatf("d%0d_hold_data", id), data, last_data[id]);
         chk($sformatf("d%0d_hold_error", id), {31'd0, er[id]}, {31'd0, last_err[id]});
      end
   endtask

   always @(negedge clock) begin
      monitor_one(0);
      monitor_one(1);
   end

   // Reference behaviour: computes the response and applies stores to the model.
   function automatic exp_t model_access(input bit w, input logic [3:0] wd, input bit sg,
                                         input logic [31:0] addr, input logic [31:0] d);
      exp_t        e;
      int          a, off;
      bit          ok;
      logic [31:0] v;
      a   = int'(addr % MEM);
      off = a % 4;
      ok  = (wd == 4'd1) || (wd == 4'd2 && off % 2 == 0) || (wd == 4'd4 && off == 0);
      e.err  = !ok;
      e.data = 32'd0;
      e.due  = 0;
      if (ok && w) begin
         for (int i = 0; i < int'(wd); i++) model[a + i] = d[8*i +: 8];
      end else if (ok) begin
         v = 32'd0;
         for (int i = 0; i < int'(wd); i++) v = v | (32'(model[a + i]) << (8 * i));
         if (sg && wd != 4'd4 && v[8*int'(wd)-1]) v = v | (32'hFFFF_FFFF << (8 * int'(wd)));
         e.data = v;
      end
      return e;
   endfunction

   task automatic issue(input bit w, input logic [3:0] wd, input bit sg,
                        input logic [31:0] addr, input logic [31:0] d, input bit abort);
      exp_t e;
      int   n;
      @(negedge clock);
      req_valid   = 1'b1;
      req_write   = w;
      req_width   = wd;
      req_signed  = sg;
      req_address = addr;
      req_data    = d;
      @(posedge clock);
      #1;
      req_valid   = 1'b0;
      req_write   = 1'($urandom);
      req_width   = 4'($urandom);
      req_signed  = 1'($urandom);
      req_address = $urandom;
      req_data    = $urandom;
      if (abort) begin
         reset = 1'b0;
         q0.delete();
         q1.delete();
         last_data[0] = 32'd0; last_data[1] = 32'd0;
         last_err[0]  = 1'b0;  last_err[1]  = 1'b0;
         repeat (2) @(negedge clock);
         reset = 1'b1;
         return;
      end
      e = model_access(w, wd, sg, addr, d);
      e.due = cycle + 1;
      q0.push_back(e);
      e.due = cycle + 1 + WS_B;
      q1.push_back(e);
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
         q0.delete();
         q1.delete();
      end
   endtask

   localparam logic [3:0] WIDTHS [9] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd3, 4'd0, 4'd8};

   initial begin
      last_data[0] = 32'd0; last_data[1] = 32'd0;
      last_err[0]  = 1'b0;  last_err[1]  = 1'b0;
      for (int i = 0; i < MEM; i++) model[i] = 8'd0;
      for (int i = 0; i < MEM / 4; i++) begin
         dut0.cells0[i] = 8'd0; dut0.cells1[i] = 8'd0; dut0.cells2[i] = 8'd0; dut0.cells3[i] = 8'd0;
         dut1.cells0[i] = 8'd0; dut1.cells1[i] = 8'd0; dut1.cells2[i] = 8'd0; dut1.cells3[i] = 8'd0;
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("reset_ready0", {31'd0, rdy[0]}, 32'd1);
      chk("reset_ready1", {31'd0, rdy[1]}, 32'd1);
      chk("reset_valid", {30'd0, vld}, 32'd0);
      chk("reset_error", {30'd0, er}, 32'd0);
      chk("reset_data0", rd0, 32'd0);
      chk("reset_data1", rd1, 32'd0);
      repeat (5) @(negedge clock);

      issue(1, 4'd4, 0, 32'h10, 32'hDEAD_BEEF, 0);
      chk("cells0_4", {24'd0, dut0.cells0[4]}, 32'hEF);
      chk("cells3_4", {24'd0, dut0.cells3[4]}, 32'hDE);
      chk("cells0_4_ws", {24'd0, dut1.cells0[4]}, 32'hEF);
      chk("cells3_4_ws", {24'd0, dut1.cells3[4]}, 32'hDE);
      issue(0, 4'd4, 0, 32'h10, 32'h0, 0);

      issue(1, 4'd4, 0, 32'h20, 32'h80FF_7F01, 0);
      issue(0, 4'd1, 1, 32'h22, 32'h0, 0);
      issue(0, 4'd1, 0, 32'h21, 32'h0, 0);
      issue(0, 4'd2, 1, 32'h22, 32'h0, 0);
      issue(0, 4'd2, 0, 32'h20, 32'h0, 0);

      issue(1, 4'd4, 0, 32'h20, 32'h1122_3344, 0);
      issue(1, 4'd2, 0, 32'h22, 32'h0000_ABCD, 0);
      issue(0, 4'd4, 0, 32'h20, 32'h0, 0);
      issue(1, 4'd1, 0, 32'h21, 32'h0000_0055, 0);
      issue(0, 4'd4, 0, 32'h20, 32'h0, 0);

      issue(1, 4'd2, 0, 32'h21, 32'hFFFF_FFFF, 0);
      issue(1, 4'd4, 0, 32'h22, 32'hFFFF_FFFF, 0);
      issue(1, 4'd3, 0, 32'h20, 32'hFFFF_FFFF, 0);
      issue(0, 4'd2, 1, 32'h23, 32'h0, 0);
      issue(0, 4'd4, 0, 32'h20, 32'h0, 0);

      issue(0, 4'd4, 0, 32'h410, 32'h0, 0);
      issue(0, 4'd4, 0, 32'hFFFF_FC10, 32'h0, 0);

      issue(1, 4'd4, 0, 32'h10, 32'h1234_5678, 1);
      issue(0, 4'd4, 0, 32'h10, 32'h0, 0);

      for (int k = 0; k < 200; k++) begin
         issue(1'($urandom), WIDTHS[$urandom_range(0, 8)], 1'($urandom),
               ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)),
               $urandom, ($urandom_range(0, 24) == 0));
      end
      repeat (6) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
